// File: rtl/seg_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl_pkg
// Shared definitions for the multiplexed seven-segment scan controller:
// scan state enumeration, the 9-bit segment word type, the hex-to-segment
// constant table and a counter-width helper.
// ---------------------------------------------------------------------------
package seg_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    // bit8 unused (0), bit7 decimal point, bits[6:0] segments g..a
    typedef logic [8:0] seg_t;

    localparam seg_t HEX_SEG_TABLE [16] = '{
        9'h03f, 9'h006, 9'h05b, 9'h04f, 9'h066, 9'h06d, 9'h07d, 9'h007,
        9'h07f, 9'h06f, 9'h077, 9'h07c, 9'h039, 9'h05e, 9'h079, 9'h071
    };

    // Width needed to count 0..v-1, never less than one bit.
    function automatic int cnt_width(input int v);
        if (v > 1) begin
            return $clog2(v);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_g_to_a.sv
// ---------------------------------------------------------------------------
// g_to_a
// Combinational hex nibble to seven-segment decoder (segments g..a,
// active-high).
// Ports:
//   hex  in  4  nibble to display
//   seg  out 7  segment pattern, bit0 = a ... bit6 = g
// ---------------------------------------------------------------------------
module g_to_a
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    seg_t full_s;

    // Table lookup; the dp/spare bits of the table word are dropped here.
    always_comb begin
        full_s = HEX_SEG_TABLE[hex];
        seg    = full_s[6:0];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed seven-segment display scanner. Each digit is lit for
// DWELL cycles followed by BLANK_CYC dark cycles. New display content is
// taken in through a valid/ready port and only becomes visible at a frame
// wrap (or immediately while idle), so a frame is never torn.
// Ports:
//   clk        in   1           system clock
//   rst        in   1           asynchronous active-high reset
//   en         in   1           scan enable, 0 = dark / idle
//   upd_valid  in   1           update request
//   upd_ready  out  1           update can be accepted (no pending update)
//   upd_data   in   4*N_DIGITS  hex nibbles, digit i = [4i+3:4i]
//   upd_dp     in   N_DIGITS    decimal points, 1 = lit
//   upd_blank  in   N_DIGITS    digit suppress, 1 = dark
//   an         out  N_DIGITS    one-hot active-high digit select
//   seg        out  9           {0, dp, g..a}
//   frame_done out  1           one-cycle pulse on the first cycle of a frame
// ---------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int N_DIGITS  = 8,
    parameter int DWELL     = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [4*N_DIGITS-1:0] upd_data,
    input  logic [N_DIGITS-1:0]   upd_dp,
    input  logic [N_DIGITS-1:0]   upd_blank,
    output logic [N_DIGITS-1:0]   an,
    output logic [8:0]            seg,
    output logic                  frame_done
);

    localparam int DW = cnt_width(DWELL);
    localparam int BW = cnt_width(BLANK_CYC);
    localparam int IW = cnt_width(N_DIGITS);

    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [BW-1:0] BLANK_LAST = (BLANK_CYC > 0) ? BW'(BLANK_CYC - 1) : '0;
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    state_t                state_r, state_n;
    logic [IW-1:0]         idx_r, idx_n;
    logic [DW-1:0]         dcnt_r, dcnt_n;
    logic [BW-1:0]         bcnt_r, bcnt_n;
    logic                  adv_s, wrap_s;

    logic [4*N_DIGITS-1:0] sh_nib_r, sh_nib_n, pend_nib_r, pend_nib_n;
    logic [N_DIGITS-1:0]   sh_dp_r, sh_dp_n, pend_dp_r, pend_dp_n;
    logic [N_DIGITS-1:0]   sh_blank_r, sh_blank_n, pend_blank_r, pend_blank_n;
    logic                  pend_full_r, pend_full_n;
    logic                  xfer_s, in_idle_s;

    logic [3:0]            nib_sel_s;
    logic [6:0]            dec_seg_s;
    logic [N_DIGITS-1:0]   an_n;
    seg_t                  seg_n;
    logic                  ready_r;
    logic [N_DIGITS-1:0]   an_r;
    seg_t                  seg_r;
    logic                  frame_done_r;

    // Scan state, digit index and dwell/blank counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            dcnt_r  <= '0;
            bcnt_r  <= '0;
        end else begin
            state_r <= state_n;
            idx_r   <= idx_n;
            dcnt_r  <= dcnt_n;
            bcnt_r  <= bcnt_n;
        end
    end

    // Next-state logic; adv_s marks the step from one digit to the next.
    always_comb begin
        state_n = state_r;
        idx_n   = idx_r;
        dcnt_n  = dcnt_r;
        bcnt_n  = bcnt_r;
        adv_s   = 1'b0;
        wrap_s  = 1'b0;
        if (!en) begin
            state_n = ST_IDLE;
            idx_n   = '0;
            dcnt_n  = '0;
            bcnt_n  = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_n = ST_SHOW;
                    idx_n   = '0;
                    dcnt_n  = '0;
                    bcnt_n  = '0;
                end
                ST_SHOW: begin
                    if (dcnt_r == DWELL_LAST) begin
                        dcnt_n = '0;
                        if (BLANK_CYC == 0) begin
                            adv_s = 1'b1;
                        end else begin
                            state_n = ST_BLANK;
                            bcnt_n  = '0;
                        end
                    end else begin
                        dcnt_n = dcnt_r + DW'(1);
                    end
                end
                ST_BLANK: begin
                    if (bcnt_r == BLANK_LAST) begin
                        bcnt_n  = '0;
                        state_n = ST_SHOW;
                        adv_s   = 1'b1;
                    end else begin
                        bcnt_n = bcnt_r + BW'(1);
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    idx_n   = '0;
                    dcnt_n  = '0;
                    bcnt_n  = '0;
                end
            endcase
            if (adv_s) begin
                if (idx_r == IDX_LAST) begin
                    idx_n  = '0;
                    wrap_s = 1'b1;
                end else begin
                    idx_n = idx_r + IW'(1);
                end
            end else begin
                wrap_s = 1'b0;
            end
        end
    end

    // Update port: direct shadow write in IDLE, otherwise park in the pending
    // register until the next frame wrap commits it.
    always_comb begin
        xfer_s       = upd_valid & ready_r;
        in_idle_s    = (state_r == ST_IDLE);
        sh_nib_n     = sh_nib_r;
        sh_dp_n      = sh_dp_r;
        sh_blank_n   = sh_blank_r;
        pend_nib_n   = pend_nib_r;
        pend_dp_n    = pend_dp_r;
        pend_blank_n = pend_blank_r;
        pend_full_n  = pend_full_r;
        if (xfer_s && in_idle_s) begin
            sh_nib_n   = upd_data;
            sh_dp_n    = upd_dp;
            sh_blank_n = upd_blank;
        end else if (wrap_s && pend_full_r) begin
            sh_nib_n    = pend_nib_r;
            sh_dp_n     = pend_dp_r;
            sh_blank_n  = pend_blank_r;
            pend_full_n = 1'b0;
        end else begin
            pend_full_n = pend_full_r;
        end
        if (xfer_s && !in_idle_s) begin
            pend_nib_n   = upd_data;
            pend_dp_n    = upd_dp;
            pend_blank_n = upd_blank;
            pend_full_n  = 1'b1;
        end else begin
            pend_nib_n = pend_nib_n;
        end
    end

    // Shadow and pending content registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_nib_r     <= '0;
            sh_dp_r      <= '0;
            sh_blank_r   <= '0;
            pend_nib_r   <= '0;
            pend_dp_r    <= '0;
            pend_blank_r <= '0;
            pend_full_r  <= 1'b0;
        end else begin
            sh_nib_r     <= sh_nib_n;
            sh_dp_r      <= sh_dp_n;
            sh_blank_r   <= sh_blank_n;
            pend_nib_r   <= pend_nib_n;
            pend_dp_r    <= pend_dp_n;
            pend_blank_r <= pend_blank_n;
            pend_full_r  <= pend_full_n;
        end
    end

    // Decoder is fed from next-cycle values so the registered outputs line
    // up with the state they describe (including freshly committed content).
    assign nib_sel_s = sh_nib_n[{idx_n, 2'b00} +: 4];

    g_to_a u_g_to_a (
        .hex (nib_sel_s),
        .seg (dec_seg_s)
    );

    // Output decode for the upcoming cycle.
    always_comb begin
        an_n  = '0;
        seg_n = '0;
        if (state_n == ST_SHOW) begin
            an_n[idx_n] = 1'b1;
            if (sh_blank_n[idx_n]) begin
                seg_n = '0;
            end else begin
                seg_n = {1'b0, sh_dp_n[idx_n], dec_seg_s};
            end
        end else begin
            an_n  = '0;
            seg_n = '0;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_r         <= '0;
            seg_r        <= '0;
            frame_done_r <= 1'b0;
            ready_r      <= 1'b1;
        end else begin
            an_r         <= an_n;
            seg_r        <= seg_n;
            frame_done_r <= wrap_s;
            ready_r      <= ~pend_full_n;
        end
    end

    assign an         = an_r;
    assign seg        = seg_r;
    assign frame_done = frame_done_r;
    assign upd_ready  = ready_r;

endmodule
